slurm32_instruction_cache: RTL and testbench
============================================

SLURM32_INSTRUCTION_CACHE -- requirements
Module: slurm32_instruction_cache

Interface
REQ-001 SHALL have parameter: INDEX_BITS, 8, line-index width (256 one-word lines).
REQ-002 SHALL have port: CLK  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: RSTb  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: instruction_request  in  1  pipeline fetch request.
REQ-005 SHALL have port: instruction_address  in  30  word address of the request.
REQ-006 SHALL have port: instruction_valid  out  1  returned word valid (one-cycle pulse per word).
REQ-007 SHALL have port: instruction_in  out  32  returned instruction word.
REQ-008 SHALL have port: instruction_address_in  out  30  word address belonging to instruction_in.
REQ-009 SHALL have port: cache_flush  in  1  invalidate all lines.
REQ-010 SHALL have port: mem_request  out  1  backing-memory read request.
REQ-011 SHALL have port: mem_address  out  30  backing-memory word address.
REQ-012 SHALL have port: mem_ack  in  1  mem_data valid this cycle; ends the transaction.
REQ-013 SHALL have port: mem_data  in  32  backing-memory read data.

Function
REQ-014 SHALL be direct-mapped: index = address[7:0], tag = address[29:8] (22 bits), one valid bit per line.
REQ-015 SHALL use states FLUSH, IDLE, LOOKUP, MISS, FILL.
REQ-016 SHALL accept a request only in IDLE, or in LOOKUP when the current lookup hits; a request in any other state or cycle is discarded and the requester re-issues it.
REQ-017 Hit: request accepted in cycle N -> instruction_valid=1 in N+1 with the cached word and the requested address; back-to-back hits stream one word per cycle.
REQ-018 Miss detected in LOOKUP (cycle N+1): instruction_valid=0; the request presented in N+1 is discarded; MISS entered at N+2.
REQ-019 MISS: mem_request=1, mem_address=miss address, both held stable until mem_ack; unbounded wait states allowed.
REQ-020 mem_ack in cycle M: data and tag written into the line, valid bit set, state FILL at M+1 with instruction_valid=1, instruction_in=mem_data captured at M, address = miss address; IDLE at M+2.
REQ-021 mem_request SHALL deassert in the cycle after mem_ack; mem_ack outside MISS is ignored.
REQ-022 A request at M+2 to the just-filled line SHALL hit.
REQ-023 FLUSH: 8-bit counter clears one valid bit per cycle, 0..255; IDLE after 256 cycles; instruction_valid=0 and requests discarded throughout.
REQ-024 cache_flush in IDLE or LOOKUP: enter FLUSH next cycle; an in-flight lookup result is dropped; flush beats a simultaneous request.
REQ-025 cache_flush in MISS: recorded; bus transaction completes, fill data discarded (no write, no instruction_valid), then FLUSH.
REQ-026 cache_flush in FLUSH: counter restarts at 0.
REQ-027 instruction_valid SHALL never assert for a line whose tag mismatches or valid bit is clear.

Reset
REQ-028 On RSTb low: state=FLUSH, counter=0, instruction_valid=0, instruction_in=0, instruction_address_in=0, mem_request=0, mem_address=0, pending-flush=0.
REQ-029 After RSTb rises the block SHALL complete a full 256-cycle FLUSH before accepting requests; a reset during MISS abandons the bus transaction.

Structure
REQ-030 Package slurm32_icache_pkg SHALL hold INDEX_BITS/TAG_BITS constants and the state enum.
REQ-031 Sub-module slurm32_icache_ram SHALL hold tag/valid/data storage (256 x 55 bits), one synchronous read port and one write port, read-during-write returns old data.

Verification
REQ-032 Reset, request 0x00000000 at cycle 0 after FLUSH -> miss; mem_request with mem_address 0x00000000; mem_ack+mem_data 0x30010003 after 3 waits -> instruction_valid one cycle later with 0x30010003.
REQ-033 Re-request 0x00000000, 0x00000001, 0x00000002 on consecutive cycles after filling -> three consecutive valid pulses, words 0x30010003, 0x30020007, 0x21030102.
REQ-034 Fill 0x00000005 then request 0x00000105 (same index, different tag) -> miss, mem_address 0x00000105, line replaced; re-request 0x00000005 -> miss.
REQ-035 cache_flush during MISS with mem_ack after 5 cycles -> no instruction_valid, FLUSH lasts 256 cycles, next request to filled address misses.
REQ-036 cache_flush and request asserted in same IDLE cycle -> no instruction_valid, mem_request stays 0, FLUSH entered.
REQ-037 RSTb low while mem_request=1 -> mem_request=0 immediately; late mem_ack ignored; post-reset request misses.

Source files
------------

// File: rtl/slurm32_icache_pkg.sv
// Shared constants and FSM state type for the SLURM32 instruction cache.
package slurm32_icache_pkg;

    localparam int unsigned ADDR_BITS  = 30;
    localparam int unsigned DATA_BITS  = 32;
    localparam int unsigned INDEX_BITS = 8;
    localparam int unsigned TAG_BITS   = ADDR_BITS - INDEX_BITS;
    localparam int unsigned LINE_BITS  = 1 + TAG_BITS + DATA_BITS;

    typedef enum logic [2:0] {
        FLUSH,
        IDLE,
        LOOKUP,
        MISS,
        FILL
    } state_t;

endpackage

// File: rtl/slurm32_icache_ram.sv
// Line storage {valid, tag, data}: one synchronous read port, one write port,
// read-during-write to the same line returns the old contents.
module slurm32_icache_ram
    import slurm32_icache_pkg::*;
#(
    parameter int unsigned ADDR_W = INDEX_BITS,
    parameter int unsigned DATA_W = LINE_BITS
) (
    input  logic              i_clk,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/slurm32_instruction_cache.sv
// Direct-mapped, one-word-line instruction cache for the SLURM32 fetch path.
// Hits return one cycle after acceptance; misses stall on the backing-memory handshake.
module slurm32_instruction_cache #(
    parameter int unsigned INDEX_BITS = slurm32_icache_pkg::INDEX_BITS
) (
    input  logic                                  CLK,
    input  logic                                  RSTb,
    input  logic                                  instruction_request,
    input  logic [slurm32_icache_pkg::ADDR_BITS-1:0] instruction_address,
    output logic                                  instruction_valid,
    output logic [slurm32_icache_pkg::DATA_BITS-1:0] instruction_in,
    output logic [slurm32_icache_pkg::ADDR_BITS-1:0] instruction_address_in,
    input  logic                                  cache_flush,
    output logic                                  mem_request,
    output logic [slurm32_icache_pkg::ADDR_BITS-1:0] mem_address,
    input  logic                                  mem_ack,
    input  logic [slurm32_icache_pkg::DATA_BITS-1:0] mem_data
);

    import slurm32_icache_pkg::*;

    localparam int unsigned TAG_W  = ADDR_BITS - INDEX_BITS;
    localparam int unsigned LINE_W = 1 + TAG_W + DATA_BITS;

    state_t                 r_state,       w_state_nxt;
    logic [INDEX_BITS-1:0]  r_flush_cnt,   w_flush_cnt_nxt;
    logic [ADDR_BITS-1:0]   r_req_addr,    w_req_addr_nxt;
    logic [ADDR_BITS-1:0]   r_mem_address, w_mem_address_nxt;
    logic                   r_mem_request, w_mem_request_nxt;
    logic                   r_flush_pend,  w_flush_pend_nxt;
    logic [DATA_BITS-1:0]   r_fill_data,   w_fill_data_nxt;

    logic                   w_rd_en;
    logic [INDEX_BITS-1:0]  w_rd_idx;
    logic [LINE_W-1:0]      w_rd_line;
    logic                   w_wr_en;
    logic [INDEX_BITS-1:0]  w_wr_idx;
    logic [LINE_W-1:0]      w_wr_line;

    logic                   w_line_valid;
    logic [TAG_W-1:0]       w_line_tag;
    logic [DATA_BITS-1:0]   w_line_data;
    logic                   w_hit;

    slurm32_icache_ram #(
        .ADDR_W (INDEX_BITS),
        .DATA_W (LINE_W)
    ) u_ram (
        .i_clk     (CLK),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_idx),
        .o_rd_data (w_rd_line),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_idx),
        .i_wr_data (w_wr_line)
    );

    assign {w_line_valid, w_line_tag, w_line_data} = w_rd_line;
    assign w_hit = w_line_valid && (w_line_tag == r_req_addr[ADDR_BITS-1:INDEX_BITS]);

    assign mem_request = r_mem_request;
    assign mem_address = r_mem_address;

    // State and datapath registers; reset abandons any bus transaction.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_state       <= FLUSH;
            r_flush_cnt   <= '0;
            r_req_addr    <= '0;
            r_mem_address <= '0;
            r_mem_request <= 1'b0;
            r_flush_pend  <= 1'b0;
            r_fill_data   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_flush_cnt   <= w_flush_cnt_nxt;
            r_req_addr    <= w_req_addr_nxt;
            r_mem_address <= w_mem_address_nxt;
            r_mem_request <= w_mem_request_nxt;
            r_flush_pend  <= w_flush_pend_nxt;
            r_fill_data   <= w_fill_data_nxt;
        end
    end

    // Next-state, RAM control and returned-word outputs.
    always_comb begin
        w_state_nxt            = r_state;
        w_flush_cnt_nxt        = r_flush_cnt;
        w_req_addr_nxt         = r_req_addr;
        w_mem_address_nxt      = r_mem_address;
        w_mem_request_nxt      = r_mem_request;
        w_flush_pend_nxt       = r_flush_pend;
        w_fill_data_nxt        = r_fill_data;
        w_rd_en                = 1'b0;
        w_rd_idx               = instruction_address[INDEX_BITS-1:0];
        w_wr_en                = 1'b0;
        w_wr_idx               = r_flush_cnt;
        w_wr_line              = '0;
        instruction_valid      = 1'b0;
        instruction_in         = '0;
        instruction_address_in = '0;

        case (r_state)
            FLUSH: begin
                w_wr_en = 1'b1;
                if (cache_flush) begin
                    w_flush_cnt_nxt = '0;
                end else if (r_flush_cnt == {INDEX_BITS{1'b1}}) begin
                    w_flush_cnt_nxt = '0;
                    w_state_nxt     = IDLE;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt + INDEX_BITS'(1);
                end
            end

            IDLE: begin
                if (cache_flush) begin
                    w_flush_cnt_nxt = '0;
                    w_state_nxt     = FLUSH;
                end else if (instruction_request) begin
                    w_rd_en        = 1'b1;
                    w_req_addr_nxt = instruction_address;
                    w_state_nxt    = LOOKUP;
                end
            end

            LOOKUP: begin
                instruction_in         = w_line_data;
                instruction_address_in = r_req_addr;
                if (cache_flush) begin
                    w_flush_cnt_nxt = '0;
                    w_state_nxt     = FLUSH;
                end else if (w_hit) begin
                    instruction_valid = 1'b1;
                    if (instruction_request) begin
                        w_rd_en        = 1'b1;
                        w_req_addr_nxt = instruction_address;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_mem_request_nxt = 1'b1;
                    w_mem_address_nxt = r_req_addr;
                    w_flush_pend_nxt  = 1'b0;
                    w_state_nxt       = MISS;
                end
            end

            MISS: begin
                if (cache_flush) begin
                    w_flush_pend_nxt = 1'b1;
                end
                // A flush seen at any point of the transaction drops the fill data.
                if (mem_ack) begin
                    w_mem_request_nxt = 1'b0;
                    if (r_flush_pend || cache_flush) begin
                        w_flush_pend_nxt = 1'b0;
                        w_flush_cnt_nxt  = '0;
                        w_state_nxt      = FLUSH;
                    end else begin
                        w_wr_en         = 1'b1;
                        w_wr_idx        = r_mem_address[INDEX_BITS-1:0];
                        w_wr_line       = {1'b1, r_mem_address[ADDR_BITS-1:INDEX_BITS], mem_data};
                        w_fill_data_nxt = mem_data;
                        w_state_nxt     = FILL;
                    end
                end
            end

            FILL: begin
                instruction_valid      = 1'b1;
                instruction_in         = r_fill_data;
                instruction_address_in = r_mem_address;
                if (cache_flush) begin
                    w_flush_cnt_nxt = '0;
                    w_state_nxt     = FLUSH;
                end else begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_flush_cnt_nxt = '0;
                w_state_nxt     = FLUSH;
            end
        endcase
    end

endmodule

// File: tb/tb_slurm32_instruction_cache.sv
// Randomized fetch streams checked against a line-level cache model and a fixed
// backing-memory image, plus directed flush/reset scenarios.
module tb_slurm32_instruction_cache;

    logic        CLK = 1'b0;
    logic        RSTb;
    logic        instruction_request;
    logic [29:0] instruction_address;
    logic        instruction_valid;
    logic [31:0] instruction_in;
    logic [29:0] instruction_address_in;
    logic        cache_flush;
    logic        mem_request;
    logic [29:0] mem_address;
    logic        mem_ack;
    logic [31:0] mem_data;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    bit          m_valid [256];
    logic [21:0] m_tag   [256];

    slurm32_instruction_cache dut (
        .CLK                    (CLK),
        .RSTb                   (RSTb),
        .instruction_request    (instruction_request),
        .instruction_address    (instruction_address),
        .instruction_valid      (instruction_valid),
        .instruction_in         (instruction_in),
        .instruction_address_in (instruction_address_in),
        .cache_flush            (cache_flush),
        .mem_request            (mem_request),
        .mem_address            (mem_address),
        .mem_ack                (mem_ack),
        .mem_data               (mem_data)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Backing memory image: fixed words for the first three addresses, a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [29:0] a);
        case (a)
            30'h0:   return 32'h30010003;
            30'h1:   return 32'h30020007;
            30'h2:   return 32'h21030102;
            default: return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
        endcase
    endfunction

    function automatic bit model_hit(input logic [29:0] a);
        return m_valid[a[7:0]] && (m_tag[a[7:0]] == a[29:8]);
    endfunction

    task automatic model_fill(input logic [29:0] a);
        m_valid[a[7:0]] = 1'b1;
        m_tag[a[7:0]]   = a[29:8];
    endtask

    task automatic model_flush();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
    endtask

    task automatic settle();
        @(negedge CLK);
    endtask

    task automatic advance();
        @(posedge CLK);
        #1;
    endtask

    // Entered in the first MISS cycle; waits = stall cycles before mem_ack.
    task automatic service_miss(input logic [29:0] a, input int waits, input int flush_at);
        for (int w = 0; w <= waits; w++) begin
            mem_ack             = (w == waits);
            mem_data            = (w == waits) ? mem_word(a) : $urandom;
            cache_flush         = (w == flush_at);
            instruction_request = 1'b1;
            instruction_address = 30'($urandom_range(0, 2));
            settle();
            check("miss_mreq", 64'(mem_request), 64'(1'b1));
            check("miss_maddr", 64'(mem_address), 64'(a));
            check("miss_nv", 64'(instruction_valid), 64'(1'b0));
            advance();
        end
        mem_ack     = 1'b0;
        cache_flush = 1'b0;
        mem_data    = $urandom;
        if (flush_at < 0) begin
            instruction_request = 1'b1;
            instruction_address = 30'($urandom_range(0, 2));
            settle();
            check("fill_v", 64'(instruction_valid), 64'(1'b1));
            check("fill_data", 64'(instruction_in), 64'(mem_word(a)));
            check("fill_addr", 64'(instruction_address_in), 64'(a));
            check("fill_mreq", 64'(mem_request), 64'(1'b0));
            model_fill(a);
            advance();
        end
        instruction_request = 1'b0;
    endtask

    // Requests presented on consecutive cycles; a discarded request is re-issued.
    task automatic run_stream(input logic [29:0] q[$], input int waits);
        logic [29:0] pend = '0;
        bit          have = 1'b0;
        int          i    = 0;
        while (i < q.size() || have) begin
            instruction_request = (i < q.size());
            instruction_address = (i < q.size()) ? q[i] : 30'($urandom);
            mem_ack             = ($urandom_range(0, 3) == 0);
            mem_data            = $urandom;
            settle();
            if (!have) begin
                check("idle_nv", 64'(instruction_valid), 64'(1'b0));
                if (i < q.size()) begin
                    pend = q[i];
                    have = 1'b1;
                    i++;
                end
                advance();
            end else if (model_hit(pend)) begin
                check("hit_v", 64'(instruction_valid), 64'(1'b1));
                check("hit_data", 64'(instruction_in), 64'(mem_word(pend)));
                check("hit_addr", 64'(instruction_address_in), 64'(pend));
                if (i < q.size()) begin
                    pend = q[i];
                    i++;
                end else begin
                    have = 1'b0;
                end
                advance();
            end else begin
                check("lookup_miss_nv", 64'(instruction_valid), 64'(1'b0));
                check("lookup_mreq", 64'(mem_request), 64'(1'b0));
                have = 1'b0;
                advance();
                service_miss(pend, (waits < 0) ? int'($urandom_range(0, 4)) : waits, -1);
            end
        end
        instruction_request = 1'b0;
        mem_ack             = 1'b0;
    endtask

    // Entered in the first FLUSH cycle; probes the exact last-flush/first-idle boundary.
    task automatic flush_wait(input logic [29:0] probe, input int waits, input int restart, input bit stray_ack);
        int len = (restart >= 0) ? restart + 1 + 256 : 256;
        model_flush();
        for (int k = 0; k < len; k++) begin
            instruction_request = (k == len - 1) || ($urandom_range(0, 1) == 1);
            instruction_address = (k == len - 1) ? probe : 30'($urandom);
            cache_flush         = (k == restart);
            mem_ack             = stray_ack && (k < 4);
            mem_data            = $urandom;
            settle();
            check("flush_nv", 64'(instruction_valid), 64'(1'b0));
            check("flush_mreq", 64'(mem_request), 64'(1'b0));
            advance();
        end
        cache_flush         = 1'b0;
        mem_ack             = 1'b0;
        instruction_request = 1'b1;
        instruction_address = probe;
        settle();
        check("post_flush_nv", 64'(instruction_valid), 64'(1'b0));
        advance();
        instruction_request = 1'b0;
        settle();
        check("probe_miss_nv", 64'(instruction_valid), 64'(1'b0));
        check("probe_lookup_mreq", 64'(mem_request), 64'(1'b0));
        advance();
        service_miss(probe, waits, -1);
    endtask

    task automatic do_reset(input logic [29:0] probe, input int waits, input bit stray_ack);
        RSTb = 1'b0;
        #1;
        check("rst_mreq", 64'(mem_request), 64'(1'b0));
        check("rst_maddr", 64'(mem_address), 64'(0));
        check("rst_v", 64'(instruction_valid), 64'(1'b0));
        check("rst_data", 64'(instruction_in), 64'(0));
        check("rst_addr", 64'(instruction_address_in), 64'(0));
        instruction_request = 1'b0;
        cache_flush         = 1'b0;
        mem_ack             = 1'b0;
        repeat (3) advance();
        RSTb = 1'b1;
        flush_wait(probe, waits, -1, stray_ack);
    endtask

    // Issue a request from IDLE that the model predicts will miss; ends in MISS cycle 0.
    task automatic start_miss(input logic [29:0] a);
        instruction_request = 1'b1;
        instruction_address = a;
        settle();
        check("sm_idle_nv", 64'(instruction_valid), 64'(1'b0));
        advance();
        instruction_request = 1'b0;
        settle();
        check("sm_lookup_nv", 64'(instruction_valid), 64'(1'b0));
        advance();
    endtask

    initial begin
        logic [29:0] q[$];
        logic [29:0] pool[$];
        RSTb                = 1'b0;
        instruction_request = 1'b0;
        instruction_address = '0;
        cache_flush         = 1'b0;
        mem_ack             = 1'b0;
        mem_data            = '0;
        model_flush();
        advance();

        // Power-up flush then first miss on address 0 with three wait states.
        do_reset(30'h0, 3, 1'b0);

        q = {}; q.push_back(30'h1); run_stream(q, 0);
        q = {}; q.push_back(30'h2); run_stream(q, 1);
        q = {}; q.push_back(30'h0); q.push_back(30'h1); q.push_back(30'h2); run_stream(q, 0);

        // Same index, different tag replaces the line.
        q = {}; q.push_back(30'h5);   run_stream(q, 2);
        q = {}; q.push_back(30'h105); run_stream(q, 0);
        q = {}; q.push_back(30'h5);   run_stream(q, 1);
        q = {}; q.push_back(30'h5);   run_stream(q, 0);

        for (int t = 0; t < 4; t++) begin
            for (int x = 0; x < 6; x++) begin
                logic [7:0] idx_tab [6];
                idx_tab = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h80, 8'hFF};
                pool.push_back({22'(t), idx_tab[x]});
            end
        end
        repeat (150) begin
            q = {};
            repeat ($urandom_range(1, 6)) q.push_back(pool[$urandom_range(0, pool.size() - 1)]);
            run_stream(q, -1);
        end

        // Flush recorded during a miss: fill dropped, then a full flush.
        start_miss(30'h3FFFF12);
        service_miss(30'h3FFFF12, 5, 2);
        flush_wait(30'h0, 1, -1, 1'b0);

        // Flush and request in the same IDLE cycle.
        instruction_request = 1'b1;
        instruction_address = 30'h0;
        cache_flush         = 1'b1;
        settle();
        check("idle_flush_nv", 64'(instruction_valid), 64'(1'b0));
        advance();
        instruction_request = 1'b0;
        cache_flush         = 1'b0;
        flush_wait(30'h1, 0, -1, 1'b0);

        // Flush during a hitting lookup drops the result.
        instruction_request = 1'b1;
        instruction_address = 30'h1;
        settle();
        advance();
        instruction_request = 1'b0;
        cache_flush         = 1'b1;
        settle();
        check("lookup_flush_nv", 64'(instruction_valid), 64'(1'b0));
        advance();
        cache_flush = 1'b0;
        flush_wait(30'h2, 0, -1, 1'b0);

        // Flush re-asserted mid-flush restarts the sweep.
        cache_flush = 1'b1;
        settle();
        advance();
        cache_flush = 1'b0;
        flush_wait(30'h0, 2, 100, 1'b0);

        // Reset during a miss abandons the transaction; a late ack is ignored.
        start_miss(30'h2ABCD);
        settle();
        check("pre_rst_mreq", 64'(mem_request), 64'(1'b1));
        advance();
        do_reset(30'h0, 0, 1'b1);

        repeat (30) begin
            q = {};
            repeat ($urandom_range(1, 6)) q.push_back(pool[$urandom_range(0, pool.size() - 1)]);
            run_stream(q, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
